// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider.
// Produces one quotient bit per clock via shift-and-subtract on an N+1-bit
// partial remainder. A start/busy/done handshake connects it to a controller.
// A zero divisor short-circuits to an all-ones quotient in a single cycle.
module seq_restoring_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N:0]    r;        // partial remainder
    logic [N-1:0]  q;        // dividend shifting out, quotient shifting in
    logic [N-1:0]  d;        // captured divisor
    logic [CW-1:0] cnt;      // iterations still to run

    logic [N:0]    t;
    logic [N:0]    s;
    logic [N:0]    r_next;
    logic [N-1:0]  q_next;
    logic          accept;

    // One restoring step: shift in the next dividend bit, trial-subtract,
    // keep the difference only when it did not go negative.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so each line sees the
        // value computed just above it; clocked state below uses '<='.
        t      = {r[N-1:0], q[N-1]};
        s      = t - {1'b0, d};
        r_next = s[N] ? t : s;
        q_next = {q[N-2:0], ~s[N]};
        accept = start && ((state == IDLE) || (state == DONE));
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, datapath included, is cleared so an
            // aborted operation leaves no partial result visible.
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= CALC;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            r           <= '0;
                            q           <= dividend;
                            d           <= divisor;
                            cnt         <= CW'(N);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                CALC: begin
                    // start is ignored here; the running operation owns d.
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next[N-1:0];
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
